// File: rtl/vga_pkg.sv
// VGA 800x600 timing constants and colour-bar table shared by the vga_timing
// slice. The colour-bar table is used only when VGA_TIMING_TEST_PATTERN_EN
// is defined.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam logic [10:0] HOR_PIXELS     = 11'd800;
  localparam logic [10:0] HOR_SYNC_START = 11'd840;
  localparam logic [10:0] HOR_SYNC_TIME  = 11'd128;
  localparam logic [10:0] HOR_TOTAL_TIME = 11'd1056;
  localparam logic [10:0] HCOUNT_MAX     = HOR_TOTAL_TIME - 11'd1;

  // Vertical timing, in lines
  localparam logic [10:0] VER_PIXELS     = 11'd600;
  localparam logic [10:0] VER_SYNC_START = 11'd601;
  localparam logic [10:0] VER_SYNC_TIME  = 11'd4;
  localparam logic [10:0] VER_TOTAL_TIME = 11'd628;
  localparam logic [10:0] VCOUNT_MAX     = VER_TOTAL_TIME - 11'd1;

  // Eight vertical colour bars, entry 0 on the left (packed: entry 7 first)
  localparam logic [7:0][11:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-timing bundle between vga_timing and the line-buffer output stage.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out  (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport sink (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_test_pattern.sv
// Colour-bar generator. Compiled only with VGA_TIMING_TEST_PATTERN_EN;
// combinational, fed with next-state counts so the top registers it
// alongside the counters.
`ifdef VGA_TIMING_TEST_PATTERN_EN
module vga_test_pattern
  import vga_pkg::*;
(
  input  logic [2:0]  bar_idx,
  input  logic        blank,
  output logic [11:0] rgb
);

  // Pick the bar colour, black during any blanking interval
  always_comb begin
    rgb = 12'h000;
    if (blank) begin
      rgb = 12'h000;
    end else begin
      rgb = bar_colour(bar_idx);
    end
  end

endmodule
`endif

// File: rtl/vga_timing.sv
// VGA pixel timing generator: h/v counters, sync and blank decode, frame
// start pulse. All outputs are registered from the next-state counts so each
// field describes the same pixel. Optional colour bars under macro
// VGA_TIMING_TEST_PATTERN_EN; without it rgb is constant black.
// Geometry parameters default to the vga_pkg constants.
module vga_timing
  import vga_pkg::*;
#(
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
  parameter logic [10:0] H_PIXELS         = HOR_PIXELS,
  parameter logic [10:0] H_SYNC_START     = HOR_SYNC_START,
  parameter logic [10:0] H_SYNC_TIME      = HOR_SYNC_TIME,
  parameter logic [10:0] H_TOTAL          = HOR_TOTAL_TIME,
  parameter logic [10:0] V_PIXELS         = VER_PIXELS,
  parameter logic [10:0] V_SYNC_START     = VER_SYNC_START,
  parameter logic [10:0] V_SYNC_TIME      = VER_SYNC_TIME,
  parameter logic [10:0] V_TOTAL          = VER_TOTAL_TIME
)(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  vga_if.out   out,
  output logic frame_start
);

  localparam logic        SYNC_ON    = SYNC_ACTIVE_HIGH ? 1'b1 : 1'b0;
  localparam logic        SYNC_OFF   = ~SYNC_ON;
  localparam logic [10:0] H_MAX      = H_TOTAL - 11'd1;
  localparam logic [10:0] V_MAX      = V_TOTAL - 11'd1;
  localparam logic [10:0] H_SYNC_END = H_SYNC_START + H_SYNC_TIME;
  localparam logic [10:0] V_SYNC_END = V_SYNC_START + V_SYNC_TIME;

  logic [10:0] hcount_r, vcount_r;
  logic        hsync_r, vsync_r, hblnk_r, vblnk_r, frame_start_r;
  logic [11:0] rgb_r;

  logic [10:0] hcount_nxt_s, vcount_nxt_s;
  logic        h_wrap_s;
  logic        hsync_nxt_s, vsync_nxt_s, hblnk_nxt_s, vblnk_nxt_s, frame_nxt_s;
  logic [11:0] rgb_nxt_s;

  // Next pixel position; >= keeps any out-of-range count from escaping
  always_comb begin
    h_wrap_s     = (hcount_r >= H_MAX);
    hcount_nxt_s = hcount_r + 11'd1;
    vcount_nxt_s = vcount_r;
    if (h_wrap_s) begin
      hcount_nxt_s = 11'd0;
      if (vcount_r >= V_MAX) begin
        vcount_nxt_s = 11'd0;
      end else begin
        vcount_nxt_s = vcount_r + 11'd1;
      end
    end else begin
      vcount_nxt_s = vcount_r;
    end
  end

  // Sync, blank and frame-start decode of the next pixel
  always_comb begin
    hblnk_nxt_s = (hcount_nxt_s >= H_PIXELS);
    vblnk_nxt_s = (vcount_nxt_s >= V_PIXELS);
    hsync_nxt_s = SYNC_OFF;
    vsync_nxt_s = SYNC_OFF;
    if ((hcount_nxt_s >= H_SYNC_START) && (hcount_nxt_s < H_SYNC_END)) begin
      hsync_nxt_s = SYNC_ON;
    end else begin
      hsync_nxt_s = SYNC_OFF;
    end
    if ((vcount_nxt_s >= V_SYNC_START) && (vcount_nxt_s < V_SYNC_END)) begin
      vsync_nxt_s = SYNC_ON;
    end else begin
      vsync_nxt_s = SYNC_OFF;
    end
    frame_nxt_s = (hcount_nxt_s == 11'd0) && (vcount_nxt_s == 11'd0);
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  vga_test_pattern u_pattern (
    .bar_idx (hcount_nxt_s[9:7]),
    .blank   (hblnk_nxt_s | vblnk_nxt_s),
    .rgb     (rgb_nxt_s)
  );
`else
  assign rgb_nxt_s = 12'h000;
`endif

  // Output registers: advance on enabled cycles, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_r      <= 11'd0;
      vcount_r      <= 11'd0;
      hsync_r       <= SYNC_OFF;
      vsync_r       <= SYNC_OFF;
      hblnk_r       <= 1'b0;
      vblnk_r       <= 1'b0;
      rgb_r         <= 12'h000;
      frame_start_r <= 1'b0;
    end else if (en) begin
      hcount_r      <= hcount_nxt_s;
      vcount_r      <= vcount_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      hblnk_r       <= hblnk_nxt_s;
      vblnk_r       <= vblnk_nxt_s;
      rgb_r         <= rgb_nxt_s;
      frame_start_r <= frame_nxt_s;
    end else begin
      frame_start_r <= 1'b0;
    end
  end

  assign out.hcount  = hcount_r;
  assign out.vcount  = vcount_r;
  assign out.hsync   = hsync_r;
  assign out.vsync   = vsync_r;
  assign out.hblnk   = hblnk_r;
  assign out.vblnk   = vblnk_r;
  assign out.rgb     = rgb_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing. dut_b uses the real 800x600 geometry
// with active-high sync; dut_s uses a tiny geometry with active-low sync so
// whole frames fit in a short run. The reference model tracks a linear
// pixel index and derives every field from it arithmetically.
module tb_vga_timing;

  localparam int HP_B = 800, HSS_B = 840, HST_B = 128, HT_B = 1056;
  localparam int VP_B = 600, VSS_B = 601, VST_B = 4,   VT_B = 628;
  localparam int HP_S = 16,  HSS_S = 18,  HST_S = 4,   HT_S = 24;
  localparam int VP_S = 6,   VSS_S = 7,   VST_S = 2,   VT_S = 9;
  localparam int FRAME_B = HT_B * VT_B;
  localparam int FRAME_S = HT_S * VT_S;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic fs_b, fs_s;

  vga_if vif_b ();
  vga_if vif_s ();

  vga_timing #(.SYNC_ACTIVE_HIGH(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .out(vif_b), .frame_start(fs_b)
  );

  vga_timing #(
    .SYNC_ACTIVE_HIGH(1'b0),
    .H_PIXELS(11'd16), .H_SYNC_START(11'd18), .H_SYNC_TIME(11'd4), .H_TOTAL(11'd24),
    .V_PIXELS(11'd6),  .V_SYNC_START(11'd7),  .V_SYNC_TIME(11'd2), .V_TOTAL(11'd9)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .out(vif_s), .frame_start(fs_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int pos_b = 0;
  int pos_s = 0;
  bit fs_en = 1'b0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic [38:0] got_b, got_s;
  assign got_b = {vif_b.hcount, vif_b.vcount, vif_b.hsync, vif_b.vsync,
                  vif_b.hblnk, vif_b.vblnk, vif_b.rgb, fs_b};
  assign got_s = {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync,
                  vif_s.hblnk, vif_s.vblnk, vif_s.rgb, fs_s};

  localparam logic [38:0] RST_B = {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
  localparam logic [38:0] RST_S = {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};

  // Reference: pixel index -> {h, v, hsync, vsync, hblnk, vblnk, rgb, frame_start}
  function automatic logic [38:0] model_vec(input int pos, input bit fs,
      input int hp, input int hss, input int hst, input int ht,
      input int vp, input int vss, input int vst, input int vt, input bit ah);
    int h, v;
    bit hs, vs, hb, vb;
    logic [11:0] rgb;
    h  = pos % ht;
    v  = (pos / ht) % vt;
    hb = (h >= hp);
    vb = (v >= vp);
    hs = ((h >= hss) && (h < hss + hst)) ? ah : !ah;
    vs = ((v >= vss) && (v < vss + vst)) ? ah : !ah;
    rgb = 12'h000;
    if (PAT && !hb && !vb) rgb = bars[(h / 128) % 8];
    return {11'(h), 11'(v), hs, vs, hb, vb, rgb, fs && (pos == 0)};
  endfunction

  function automatic logic [38:0] exp_b();
    return model_vec(pos_b, fs_en, HP_B, HSS_B, HST_B, HT_B, VP_B, VSS_B, VST_B, VT_B, 1'b1);
  endfunction

  function automatic logic [38:0] exp_s();
    return model_vec(pos_s, fs_en, HP_S, HSS_S, HST_S, HT_S, VP_S, VSS_S, VST_S, VT_S, 1'b0);
  endfunction

  // One clock with the given enable; model advances on enabled cycles only
  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      pos_b = (pos_b + 1) % FRAME_B;
      pos_s = (pos_s + 1) % FRAME_S;
    end
    fs_en = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (got_b !== RST_B) $display("FAIL reset_b: got %h want %h", got_b, RST_B);
    else n_pass++;
    n_checks++;
    if (got_s !== RST_S) $display("FAIL reset_s: got %h want %h", got_s, RST_S);
    else n_pass++;
    en = 1'b0;
    rst_n = 1'b1;
    pos_b = 0; pos_s = 0; fs_en = 1'b0;
  endtask

  task automatic test_first_line();
    for (int i = 1; i <= HT_B; i++) begin
      step(1'b1);
      n_checks++;
      if (got_b !== exp_b()) $display("FAIL first_line_b cyc %0d: got %h want %h", i, got_b, exp_b());
      else n_pass++;
      n_checks++;
      if (got_s !== exp_s()) $display("FAIL first_line_s cyc %0d: got %h want %h", i, got_s, exp_s());
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (vif_b.hcount !== 11'd1 || vif_b.vcount !== 11'd0 || fs_b !== 1'b0)
          $display("FAIL first_pixel: got h=%0d v=%0d fs=%b want h=1 v=0 fs=0",
                   vif_b.hcount, vif_b.vcount, fs_b);
        else n_pass++;
      end
      if (i == HT_B) begin
        n_checks++;
        if (vif_b.hcount !== 11'd0 || vif_b.vcount !== 11'd1)
          $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=1", vif_b.hcount, vif_b.vcount);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hsync_edges();
    int tgt_b [4] = '{839, 840, 967, 968};
    bit want_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int tgt_s [4] = '{17, 18, 21, 22};
    bit want_s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2 * HT_B && (pos_b % HT_B) != tgt_b[k]; n++) step(1'b1);
      n_checks++;
      if ((pos_b % HT_B) != tgt_b[k] || vif_b.hsync !== want_b[k])
        $display("FAIL hsync_b h=%0d: got %b at %0d want %b", tgt_b[k], vif_b.hsync, vif_b.hcount, want_b[k]);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2 * HT_S && (pos_s % HT_S) != tgt_s[k]; n++) step(1'b1);
      n_checks++;
      if ((pos_s % HT_S) != tgt_s[k] || vif_s.hsync !== want_s[k])
        $display("FAIL hsync_s h=%0d: got %b at %0d want %b", tgt_s[k], vif_s.hsync, vif_s.hcount, want_s[k]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    for (int n = 0; n < 2 * HT_B && (pos_b % HT_B) != 500; n++) step(1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      n_checks++;
      if (got_b !== exp_b() || fs_b !== 1'b0 || vif_b.hcount !== 11'd500)
        $display("FAIL hold_b cyc %0d: got %h want %h", i, got_b, exp_b());
      else n_pass++;
      n_checks++;
      if (got_s !== exp_s()) $display("FAIL hold_s cyc %0d: got %h want %h", i, got_s, exp_s());
      else n_pass++;
    end
    step(1'b1);
    n_checks++;
    if (vif_b.hcount !== 11'd501 || got_b !== exp_b())
      $display("FAIL hold_resume: got h=%0d want h=501", vif_b.hcount);
    else n_pass++;
  endtask

  task automatic test_random();
    int fs_got = 0, fs_exp = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0);
      if (fs_en && pos_s == 0) fs_exp++;
      if (fs_s === 1'b1) fs_got++;
      n_checks++;
      if (got_b !== exp_b()) $display("FAIL random_b cyc %0d: got %h want %h", i, got_b, exp_b());
      else n_pass++;
      n_checks++;
      if (got_s !== exp_s()) $display("FAIL random_s cyc %0d: got %h want %h", i, got_s, exp_s());
      else n_pass++;
    end
    n_checks++;
    if (fs_got != fs_exp || fs_exp == 0)
      $display("FAIL random_frame_count: got %0d want %0d", fs_got, fs_exp);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int fs_cnt = 0;
    bit vs_on [VT_S];
    for (int v = 0; v < VT_S; v++) vs_on[v] = 1'b0;
    for (int n = 0; n < FRAME_S && pos_s != 5; n++) step(1'b1);
    for (int i = 0; i < FRAME_S; i++) begin
      step(1'b1);
      if (fs_s === 1'b1) begin
        fs_cnt++;
        n_checks++;
        if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0)
          $display("FAIL frame_start_pos: got h=%0d v=%0d want 0,0", vif_s.hcount, vif_s.vcount);
        else n_pass++;
      end
      if (vif_s.vsync === 1'b0 && vif_s.vcount < 11'(VT_S)) vs_on[vif_s.vcount] = 1'b1;
    end
    n_checks++;
    if (fs_cnt != 1) $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
    else n_pass++;
    for (int v = 0; v < VT_S; v++) begin
      n_checks++;
      if (vs_on[v] !== ((v >= VSS_S) && (v < VSS_S + VST_S)))
        $display("FAIL vsync_line %0d: got %b want %b", v, vs_on[v], (v >= VSS_S) && (v < VSS_S + VST_S));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 2 * HT_B && (pos_b % HT_B) != 700; n++) step(1'b1);
    en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (got_b !== RST_B) $display("FAIL async_reset_b: got %h want %h", got_b, RST_B);
    else n_pass++;
    n_checks++;
    if (got_s !== RST_S) $display("FAIL async_reset_s: got %h want %h", got_s, RST_S);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (got_b !== RST_B) $display("FAIL reset_held: got %h want %h", got_b, RST_B);
    else n_pass++;
    rst_n = 1'b1;
    pos_b = 0; pos_s = 0; fs_en = 1'b0;
    step(1'b1);
    n_checks++;
    if (got_b !== exp_b() || vif_b.hcount !== 11'd1 || fs_b !== 1'b0)
      $display("FAIL post_reset: got %h want %h", got_b, exp_b());
    else n_pass++;
  endtask

  task automatic test_pattern();
    int tgt [3] = '{127, 128, 800};
    logic [11:0] want [3];
    want[0] = PAT ? bars[0] : 12'h000;
    want[1] = PAT ? bars[1] : 12'h000;
    want[2] = 12'h000;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 2 * HT_B && (pos_b % HT_B) != tgt[k]; n++) step(1'b1);
      n_checks++;
      if ((pos_b % HT_B) != tgt[k] || vif_b.rgb !== want[k])
        $display("FAIL pattern h=%0d: got %h want %h", tgt[k], vif_b.rgb, want[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_hsync_edges();
    test_hold();
    test_random();
    test_full_frame();
    test_reset_mid();
    test_pattern();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL expose parameter SYNC_ACTIVE_HIGH, default 1, meaning hsync/vsync asserted level is 1 when set and 0 when cleared.
REQ-002 The module SHALL have port clk, input, 1, the single clock domain; one clock; reset is asynchronous and active-low.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port en, input, 1, pixel-advance enable; counters advance only on clk edges with en=1.
REQ-005 The module SHALL have port out, vga_if.out modport, carrying hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0] to the downstream line-buffer output stage.
REQ-006 The module SHALL have port frame_start, output, 1, single-cycle pulse marking pixel (0,0).

Function
REQ-007 The internal hcount SHALL increment by 1 per enabled cycle, wrap from HCOUNT_MAX (HOR_TOTAL_TIME-1) to 0.
REQ-008 The internal vcount SHALL increment only on the enabled cycle where hcount wraps, and wrap from VCOUNT_MAX (VER_TOTAL_TIME-1) to 0 on that same cycle.
REQ-009 All outputs SHALL be registered; sync, blank and frame_start SHALL be decoded from the next-state counts so that every out field refers to the same pixel in the same cycle.
REQ-010 hblnk SHALL be 1 iff out.hcount >= HOR_PIXELS; vblnk SHALL be 1 iff out.vcount >= VER_PIXELS.
REQ-011 hsync SHALL be at its active level iff HOR_SYNC_START <= out.hcount < HOR_SYNC_START+HOR_SYNC_TIME; vsync likewise with VER_SYNC_START/VER_SYNC_TIME.
REQ-012 frame_start SHALL be 1 for exactly one enabled cycle, when out.hcount=0 and out.vcount=0, and 0 otherwise.
REQ-013 With en=0, all outputs SHALL hold their values; frame_start SHALL be 0 during any held cycle.
REQ-014 Simultaneous h-wrap and v-wrap SHALL yield out.hcount=0, out.vcount=0, frame_start=1 in one cycle.
REQ-015 Counter arithmetic SHALL be 11-bit unsigned; values above the MAX constants SHALL be unreachable.
REQ-016 Without the test-pattern feature, out.rgb SHALL be 12'h000 at all times.

Reset
REQ-017 Asserting rst_n=0, including mid-frame, SHALL immediately force counts to 0, hsync/vsync inactive, hblnk=0, vblnk=0, rgb=12'h000, frame_start=0.
REQ-018 On the first enabled cycle after rst_n deasserts, outputs SHALL show pixel (1,0); (0,0) is the reset state and does not produce frame_start.

Configuration
REQ-019 With macro VGA_TIMING_TEST_PATTERN_EN defined, out.rgb SHALL carry 8 vertical colour bars, bar index = out.hcount[9:7], colour from a fixed 8-entry table, and 12'h000 whenever hblnk or vblnk is 1, aligned with the counts.
REQ-020 Without VGA_TIMING_TEST_PATTERN_EN, no pattern logic SHALL be synthesised and REQ-016 applies.

Structure
REQ-021 HOR_PIXELS=800, HOR_SYNC_START=840, HOR_SYNC_TIME=128, HOR_TOTAL_TIME=1056, HCOUNT_MAX, and VER_PIXELS=600, VER_SYNC_START=601, VER_SYNC_TIME=4, VER_TOTAL_TIME=628, VCOUNT_MAX SHALL reside in vga_pkg, together with the colour-bar table.
REQ-022 The colour-bar generator SHALL be a sub-module vga_test_pattern, instantiated only under VGA_TIMING_TEST_PATTERN_EN; counters and sync decode stay in vga_timing.

Verification
REQ-023 Reset then en=1 for 1056 cycles -> out.hcount runs 1..1055,0; out.vcount steps 0->1 on the wrap cycle.
REQ-024 Run to out.hcount=839/840/967/968 -> hsync inactive/active/active/inactive with SYNC_ACTIVE_HIGH=1; inverted with 0.
REQ-025 Full frame (663168 cycles) -> exactly one frame_start at (0,0); vsync active for vcount 601..604 only; vblnk from vcount 600.
REQ-026 Toggle en=0 for 10 cycles at hcount=500 -> all outputs frozen, frame_start 0; resume continues at 501.
REQ-027 Assert rst_n=0 at (700,300) -> outputs return to reset values that same clock phase, independent of clk.
REQ-028 With VGA_TIMING_TEST_PATTERN_EN: hcount=128 vs 127 -> rgb switches table entry 1 vs 0; hcount=800 -> rgb=12'h000.
